// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 32-way round-robin arbiter.
package arb_pkg;

   localparam int unsigned N_REQ = 32;
   localparam int unsigned IDX_W = 5;
   // Hold counter wide enough for the largest legal hold limit (255).
   localparam int unsigned CNT_W = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/rr_arbiter_32_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_arbiter_32_if;
   import arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_valid;
   logic             timeout;

   modport master (
      output req,
      input  gnt,
      input  gnt_idx,
      input  gnt_valid,
      input  timeout
   );

   modport slave (
      input  req,
      output gnt,
      output gnt_idx,
      output gnt_valid,
      output timeout
   );

endinterface

// File: rtl/encoder_32x5.sv
// One-hot to binary encoder; an all-zero input yields 31.
module encoder_32x5
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] onehot,
   output logic [IDX_W-1:0] idx
);

   // Lowest set bit wins; with no bit set the default index survives.
   always_comb begin
      idx = IDX_W'(N_REQ - 1);
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         if (onehot[i]) idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/rr_arbiter_32.sv
// Round-robin arbiter for 32 requesters with a bounded hold time.
module rr_arbiter_32
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
)
(
   input  logic            clk,
   input  logic            rst_n,
   rr_arbiter_32_if.slave  bus
);

   state_t           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             valid_q, valid_d;
   logic             to_q, to_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [IDX_W-1:0]   base;
   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   logic [IDX_W-1:0]   pick_off;
   logic [IDX_W-1:0]   winner;
   logic [IDX_W-1:0]   raw_idx;

   // Rotate so the slot after the last owner sits at bit 0, pick lowest, rotate back.
   always_comb begin
      base     = ptr_q + IDX_W'(1);
      dbl      = {bus.req, bus.req} >> base;
      rot      = dbl[N_REQ-1:0];
      pick_off = '0;
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         if (rot[i]) pick_off = IDX_W'(i);
      end
      winner = pick_off + base;
   end

   // Next-state and next-output decode.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      valid_d = valid_q;
      to_d    = 1'b0;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            gnt_d   = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
            if (|bus.req) begin
               state_d = ST_GRANT;
               gnt_d   = N_REQ'(1) << winner;
               valid_d = 1'b1;
               ptr_d   = winner;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_GRANT: begin
            if (!bus.req[ptr_q]) begin
               // Owner let go; this wins over an expiring hold limit.
               state_d = ST_IDLE;
               gnt_d   = '0;
               valid_d = 1'b0;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(MAX_HOLD)) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               valid_d = 1'b0;
               cnt_d   = '0;
               to_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   // State and output registers; pointer resets to 31 so the first search starts at bit 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         valid_q <= 1'b0;
         to_q    <= 1'b0;
         ptr_q   <= IDX_W'(N_REQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
         to_q    <= to_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   encoder_32x5 u_gnt_enc (
      .onehot (gnt_q),
      .idx    (raw_idx)
   );

   // Encoder reports 31 when idle, so gate the index with the valid flag.
   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = raw_idx & {IDX_W{valid_q}};
   assign bus.gnt_valid = valid_q;
   assign bus.timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter_32.sv
// Self-checking bench for rr_arbiter_32 against a behavioural round-robin model.
module tb_rr_arbiter_32;
   import arb_pkg::*;

   localparam int unsigned HOLD = 4;

   logic clk;
   logic rst_n;
   rr_arbiter_32_if bus ();

   rr_arbiter_32 #(.MAX_HOLD(HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fails  = 0;

   // Behavioural model: current owner (-1 = none), last owner, cycles held, timeout flag.
   int   m_owner;
   int   m_last;
   int   m_held;
   logic m_to;

   logic [31:0] r;
   logic [31:0] prev;

   logic [31:0] alt_req [10] = '{32'h5, 32'h5, 32'h4, 32'h5, 32'h5, 32'h1, 32'h5, 32'h5, 32'h4, 32'h5};
   logic        alt_vld [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [4:0]  alt_idx [10] = '{5'd0, 5'd0, 5'd0, 5'd2, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2};

   logic [31:0] wrp_req [7] = '{32'h4000_0000, 32'h0000_0003, 32'h4000_0003, 32'h4000_0002,
                                32'h4000_0003, 32'h4000_0001, 32'h4000_0003};
   logic        wrp_vld [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [4:0]  wrp_idx [7] = '{5'd30, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd30};

   logic        to_vld [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   logic        to_to  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void model_reset();
      m_owner = -1;
      m_last  = 31;
      m_held  = 0;
      m_to    = 1'b0;
   endfunction

   // One clock of arbiter behaviour, written from the round-robin rules.
   function automatic void model_step(input logic [31:0] rq);
      if (m_owner < 0) begin
         m_to = 1'b0;
         for (int k = 1; k <= 32; k++) begin
            int c;
            c = (m_last + k) % 32;
            if (rq[c]) begin
               m_owner = c;
               m_last  = c;
               m_held  = 1;
               break;
            end
         end
      end else if (!rq[m_owner]) begin
         m_owner = -1;
         m_to    = 1'b0;
      end else if (m_held == int'(HOLD)) begin
         m_owner = -1;
         m_to    = 1'b1;
      end else begin
         m_held++;
         m_to = 1'b0;
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] eg;
      logic [31:0] ei;
      eg = (m_owner < 0) ? 32'h0 : (32'h1 << m_owner);
      ei = (m_owner < 0) ? 32'h0 : 32'(m_owner);
      check({tag, "/gnt"},     bus.gnt,                eg);
      check({tag, "/gnt_idx"}, 32'(bus.gnt_idx),       ei);
      check({tag, "/valid"},   32'(bus.gnt_valid),     32'(m_owner >= 0));
      check({tag, "/timeout"}, 32'(bus.timeout),       32'(m_to));
   endtask

   task automatic step(input logic [31:0] rq, input string tag);
      bus.req = rq;
      @(posedge clk);
      model_step(rq);
      #1;
      check_model(tag);
   endtask

   // Short reset pulse placed between edges.
   task automatic do_reset();
      rst_n   = 1'b0;
      bus.req = '0;
      model_reset();
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b0;
      bus.req = '0;
      prev    = '0;
      model_reset();
      #1;
      check_model("reset");
      #2;
      rst_n = 1'b1;

      step(32'h0000_0001, "single");
      check("single_gnt_const", bus.gnt, 32'h1);
      check("single_idx_const", 32'(bus.gnt_idx), 32'h0);

      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(alt_req[i], "alt");
         check("alt_valid_const", 32'(bus.gnt_valid), 32'(alt_vld[i]));
         check("alt_idx_const",   32'(bus.gnt_idx),   32'(alt_idx[i]));
      end

      do_reset();
      for (int i = 0; i < 7; i++) begin
         step(wrp_req[i], "wrap");
         check("wrap_valid_const", 32'(bus.gnt_valid), 32'(wrp_vld[i]));
         check("wrap_idx_const",   32'(bus.gnt_idx),   32'(wrp_idx[i]));
      end

      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(32'h0000_0100, "hold");
         check("hold_valid_const",   32'(bus.gnt_valid), 32'(to_vld[i]));
         check("hold_timeout_const", 32'(bus.timeout),   32'(to_to[i]));
      end

      // Owner drop on the same cycle the hold limit is reached is a normal release.
      do_reset();
      for (int i = 0; i < 4; i++) step(32'h0000_0100, "simul");
      step(32'h0, "simul_drop");
      check("simul_timeout_const", 32'(bus.timeout),   32'h0);
      check("simul_valid_const",   32'(bus.gnt_valid), 32'h0);

      // Asynchronous reset while idx 5 owns the grant.
      do_reset();
      step(32'h0000_0020, "areset_pre");
      check("areset_pre_idx_const", 32'(bus.gnt_idx), 32'd5);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("areset_gnt",     bus.gnt,               32'h0);
      check("areset_idx",     32'(bus.gnt_idx),      32'h0);
      check("areset_valid",   32'(bus.gnt_valid),    32'h0);
      check("areset_timeout", 32'(bus.timeout),      32'h0);
      #1;
      rst_n = 1'b1;
      step(32'h0000_0020, "areset_post");
      check("areset_post_idx_const",   32'(bus.gnt_idx),   32'd5);
      check("areset_post_valid_const", 32'(bus.gnt_valid), 32'h1);

      // Randomised traffic against the model.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 4))
            0: r = '0;
            1: r = $urandom & $urandom & $urandom;
            2: r = prev | (32'h1 << $urandom_range(0, 31));
            3: r = prev;
            default: r = (m_owner >= 0) ? (prev & ~(32'h1 << m_owner)) : $urandom;
         endcase
         prev = r;
         step(r, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_32.md
# rr_arbiter_32

Round-robin arbiter that shares one single-owner resource among 32 requesters in the KGP miniRISC system, for example a shared memory port or a register-file write port. It registers a one-hot grant, a 5-bit encoded owner index and a valid flag. It holds each grant until the owner drops its request or a hold timeout expires. Fairness comes from a rotating priority pointer: the most recent owner gets lowest priority in the next arbitration.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one owner may hold the grant. Legal range 1..255.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 32: request vector; bit i is requester i and is level-sensitive.
- `gnt` output 32: one-hot grant, all-zero when idle.
- `gnt_idx` output 5: binary index of the set `gnt` bit; 0 when `gnt_valid`=0.
- `gnt_valid` output 1: high whenever `gnt` is non-zero.
- `timeout` output 1: one-cycle pulse when a grant is force-released by the hold limit.

## Operation
- Two states: `IDLE` and `GRANT`.
- **Reset values:**
  - state = `IDLE`.
  - `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `timeout`=0.
  - priority pointer `ptr`=31, so the first search starts at bit 0.
  - hold counter = 0.
- **IDLE:**
  - If `req`≠0, pick the winner: the first set bit of `req` scanning ptr+1, ptr+2, … with modulo-32 wrap.
  - Next state `GRANT`. `gnt`=onehot(winner), `gnt_valid`=1, `ptr`←winner, counter←1.
  - If `req`=0, stay `IDLE` with all grant outputs 0.
- **GRANT:**
  - **Normal release:** if `req[ptr]`=0, go to `IDLE`. Outputs clear on the next edge.
  - **Forced release:** else if counter = `MAX_HOLD`, go to `IDLE`. Outputs clear on the next edge and `timeout`=1 for exactly that `IDLE` cycle.
  - Otherwise keep the grant and increment the counter.
- Every release passes through exactly one `IDLE` (bubble) cycle. Arbitration in that cycle uses the updated `ptr`, so the former owner has lowest priority.
- A forced-released owner that still requests is re-granted after the bubble only if no other bit of `req` is set.
- Changes on non-owner `req` bits during `GRANT` have no effect until the next `IDLE` cycle.
- Winner arithmetic:
  - Rotate `req` right by (ptr+1) mod 32.
  - Priority-pick the lowest set bit.
  - Add (ptr+1) back with 5-bit wrap.
- `gnt_idx` is produced by encoding `gnt`, then masked with `gnt_valid`, because the encoder returns 31 for an all-zero input.

## Timing
- **Request-to-grant latency:** `req` high before edge k while `IDLE` → `gnt`/`gnt_valid`/`gnt_idx` high after edge k. All outputs are registered.
- **Release latency:** owner drops `req` before edge k → grant outputs 0 after edge k.
- **Next grant:** earliest one edge after release, at edge k+1.
- **Maximum hold:** `gnt_valid` stays high for exactly `MAX_HOLD` consecutive cycles.
- **Simultaneous events in the same cycle:**
  - Owner `req` drop together with counter = `MAX_HOLD` counts as a normal release; `timeout` stays 0.
- **Reset mid-operation:** `rst_n` low clears all outputs and state immediately, without waiting for `clk`.
- **Reset release:** first arbitration occurs on the first rising edge with `rst_n` high.

## Structure
- Shared package `arb_pkg`:
  - `N_REQ`=32, `IDX_W`=5.
  - State encodings `ST_IDLE`=1'b0, `ST_GRANT`=1'b1.
- One sub-module: the existing `encoder_32x5`, instantiated as `u_gnt_enc` with `gnt` → raw index.
- Everything else lives in the top level: rotate/priority-pick, pointer, hold counter, state register.

## Test plan
- **Reset then single request:** deassert `rst_n`, set `req`=32'h0000_0001 → after the first edge, `gnt`=32'h1, `gnt_idx`=0, `gnt_valid`=1, `timeout`=0.
- **Alternation:** `req`=32'h0000_0005; each owner drops its bit for one cycle, 2 cycles after being granted → grant sequence idx 0, 2, 0, 2, with one zero cycle between grants.
- **Wrap-around:** owner idx 30 releases while `req`=32'h4000_0003 → next grants are idx 0, then 1, then 30.
- **Timeout:** `MAX_HOLD`=4, `req`=32'h0000_0100 held constantly:
  - `gnt_valid` high for 4 cycles.
  - Then one cycle with `gnt`=0 and `timeout`=1.
  - Then idx 8 re-granted.
- **Async reset mid-grant:** pull `rst_n` low between edges while idx 5 is granted → all outputs 0 immediately. Release reset with `req`=32'h0000_0020 → idx 5 granted on the next edge.
